// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and per-boundary layout constants for pipe_stage_reg
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Payload / control widths at each boundary of the 5-stage core
    localparam int IFID_DATA_W  = 64;
    localparam int IFID_CTRL_W  = 4;
    localparam int IDEX_DATA_W  = 160;
    localparam int IDEX_CTRL_W  = 8;
    localparam int EXMEM_DATA_W = 112;
    localparam int EXMEM_CTRL_W = 6;
    localparam int MEMWB_DATA_W = 80;
    localparam int MEMWB_CTRL_W = 4;

    // ID/EX payload layout (LSB offsets and widths)
    localparam int IDEX_PC_LSB    = 0;
    localparam int IDEX_PC_W      = 32;
    localparam int IDEX_RS1V_LSB  = 32;
    localparam int IDEX_RS2V_LSB  = 64;
    localparam int IDEX_IMM_LSB   = 96;
    localparam int IDEX_OPND_W    = 32;
    localparam int IDEX_RD_LSB    = 128;
    localparam int IDEX_RS1_LSB   = 133;
    localparam int IDEX_RS2_LSB   = 138;
    localparam int IDEX_REG_W     = 5;
    localparam int IDEX_CYCLE_LSB = 143;
    localparam int IDEX_CYCLE_W   = 17;

    // IF/ID payload layout
    localparam int IFID_PC_LSB    = 0;
    localparam int IFID_INSN_LSB  = 32;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - single pipeline entry holding valid, data and ctrl
module pipe_slot #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Load wins over clear; clear drops valid and zeroes ctrl but leaves data untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_d;
            ctrl  <= ctrl_d;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with handshake, flush, kill and optional skid
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 8,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              kill_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              accept;
    logic              drain;
    logic [CTRL_W-1:0] cap_ctrl;

    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = out_valid & out_ready;
    assign cap_ctrl = kill_in ? '0 : in_ctrl;

    generate
        if (SKID == 0) begin : gen_single
            logic              main_valid;
            logic [DATA_W-1:0] main_data;
            logic [CTRL_W-1:0] main_ctrl;

            assign in_ready = out_ready | ~main_valid;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
                .clk    (clk),
                .rst    (rst),
                .load   (accept),
                .clear  (flush | drain),
                .data_d (in_data),
                .ctrl_d (cap_ctrl),
                .valid  (main_valid),
                .data   (main_data),
                .ctrl   (main_ctrl)
            );

            assign out_valid = main_valid;
            assign out_data  = main_data;
            assign out_ctrl  = main_ctrl;
        end else begin : gen_skid
            pipe_state_t       state;
            logic              main_load;
            logic              main_clear;
            logic              skid_load;
            logic              skid_clear;
            logic [DATA_W-1:0] main_d;
            logic [CTRL_W-1:0] main_c;
            logic              main_valid;
            logic [DATA_W-1:0] main_data;
            logic [CTRL_W-1:0] main_ctrl;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // in_ready comes straight from a flop, so there is no path from out_ready
            assign in_ready = ~skid_valid;

            // Slot steering: main reloads from input or from skid, skid only fills from ONE
            always_comb begin
                main_load  = 1'b0;
                skid_load  = 1'b0;
                skid_clear = 1'b0;
                main_d     = in_data;
                main_c     = cap_ctrl;
                case (state)
                    EMPTY: main_load = accept;
                    ONE: begin
                        main_load = accept & drain;
                        skid_load = accept & ~drain;
                    end
                    FULL: begin
                        main_load  = drain & ~flush;
                        skid_clear = drain;
                        main_d     = skid_data;
                        main_c     = skid_ctrl;
                    end
                    default: main_load = 1'b0;
                endcase
                main_clear = flush | (drain & ~main_load);
                skid_clear = skid_clear | flush;
            end

            // Occupancy FSM tracking how many slots hold a beat
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state <= EMPTY;
                end else begin
                    case (state)
                        EMPTY: if (accept) state <= ONE;
                        ONE: begin
                            if (accept && !drain) state <= FULL;
                            else if (drain && !accept) state <= EMPTY;
                        end
                        FULL: if (drain) state <= ONE;
                        default: state <= EMPTY;
                    endcase
                end
            end

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
                .clk    (clk),
                .rst    (rst),
                .load   (main_load),
                .clear  (main_clear),
                .data_d (main_d),
                .ctrl_d (main_c),
                .valid  (main_valid),
                .data   (main_data),
                .ctrl   (main_ctrl)
            );

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (skid_load),
                .clear  (skid_clear),
                .data_d (in_data),
                .ctrl_d (cap_ctrl),
                .valid  (skid_valid),
                .data   (skid_data),
                .ctrl   (skid_ctrl)
            );

            assign out_valid = main_valid;
            assign out_data  = main_data;
            assign out_ctrl  = main_ctrl;
        end
    endgenerate

    // Saturating count of beats accepted with their ctrl killed
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (accept && kill_in && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table-driven bench for pipe_stage_reg in both modes
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        kill_in;
    logic        flush;
    logic        out_ready;

    logic        r0, v0;
    logic [31:0] d0;
    logic [7:0]  c0;
    logic [15:0] b0;
    logic        r1, v1;
    logic [31:0] d1;
    logic [7:0]  c1;
    logic [3:0]  b1;

    int pass_cnt = 0;
    int total_cnt = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0),
        .in_data(in_data), .in_ctrl(in_ctrl), .kill_in(kill_in), .flush(flush),
        .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_ctrl(c0),
        .bubble_cnt(b0)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .in_ctrl(in_ctrl), .kill_in(kill_in), .flush(flush),
        .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_ctrl(c1),
        .bubble_cnt(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic [7:0]  ic;
        logic        k;
        logic        f;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic        chk_d;
        logic [7:0]  ec;
        logic        erdy;
        logic [3:0]  eb;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic [7:0] ic,
                         input logic k, input logic f, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        in_ctrl   = ic;
        kill_in   = k;
        flush     = f;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        chk("rst_v0", v0, 0);
        chk("rst_d0", d0, 0);
        chk("rst_c0", c0, 0);
        chk("rst_b0", b0, 0);
        chk("rst_r0", r0, 1);
        chk("rst_v1", v1, 0);
        chk("rst_d1", d1, 0);
        chk("rst_b1", b1, 0);
        chk("rst_r1", r1, 1);

        //                iv id      ic     k f ordy  ev ed     chkd ec    erdy eb
        for (int i = 1; i <= 8; i++)
            tbl.push_back('{1, i,      8'hA5, 0, 0, 1,  1, i,      1, 8'hA5, 1, 0});
        tbl.push_back('{0, 32'h0,  8'h00, 0, 0, 1,  0, 32'h0,  0, 8'h00, 1, 0});
        tbl.push_back('{1, 32'h10, 8'h01, 0, 0, 0,  1, 32'h10, 1, 8'h01, 1, 0});
        tbl.push_back('{1, 32'h11, 8'h02, 0, 0, 0,  1, 32'h10, 1, 8'h01, 0, 0});
        tbl.push_back('{1, 32'h12, 8'h03, 0, 0, 0,  1, 32'h10, 1, 8'h01, 0, 0});
        tbl.push_back('{0, 32'h0,  8'h00, 0, 0, 1,  1, 32'h11, 1, 8'h02, 1, 0});
        tbl.push_back('{0, 32'h0,  8'h00, 0, 0, 1,  0, 32'h0,  0, 8'h00, 1, 0});
        tbl.push_back('{1, 32'h55, 8'hFF, 1, 0, 0,  1, 32'h55, 1, 8'h00, 1, 1});
        tbl.push_back('{0, 32'h0,  8'h00, 0, 0, 1,  0, 32'h0,  0, 8'h00, 1, 1});
        tbl.push_back('{1, 32'h20, 8'h11, 0, 0, 0,  1, 32'h20, 1, 8'h11, 1, 1});
        tbl.push_back('{1, 32'h21, 8'h12, 1, 0, 0,  1, 32'h20, 1, 8'h11, 0, 2});
        tbl.push_back('{1, 32'h22, 8'h13, 1, 1, 0,  0, 32'h0,  0, 8'h00, 1, 2});
        tbl.push_back('{1, 32'h30, 8'h07, 0, 0, 0,  1, 32'h30, 1, 8'h07, 1, 2});
        tbl.push_back('{1, 32'h31, 8'h08, 1, 1, 1,  0, 32'h0,  0, 8'h00, 1, 2});
        tbl.push_back('{0, 32'h0,  8'h00, 0, 0, 1,  0, 32'h0,  0, 8'h00, 1, 2});

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ic, tbl[i].k, tbl[i].f, tbl[i].ordy);
            tick();
            chk($sformatf("tbl%0d_valid", i), v1, tbl[i].ev);
            if (tbl[i].chk_d) chk($sformatf("tbl%0d_data", i), d1, tbl[i].ed);
            chk($sformatf("tbl%0d_ctrl", i), c1, tbl[i].ec);
            chk($sformatf("tbl%0d_in_ready", i), r1, tbl[i].erdy);
            chk($sformatf("tbl%0d_bubble", i), b1, tbl[i].eb);
        end

        // Single-entry mode: pass-through with combinational in_ready, then stall hold
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, 8'hA5, 1'b0, 1'b0, 1'b1);
            #1;
            chk($sformatf("s0_rdy%0d", i), r0, 1);
            tick();
            chk($sformatf("s0_v%0d", i), v0, 1);
            chk($sformatf("s0_d%0d", i), d0, i);
            chk($sformatf("s0_c%0d", i), c0, 8'hA5);
        end
        drive(1'b1, 32'h40, 8'h3C, 1'b0, 1'b0, 1'b0);
        #1;
        chk("s0_stall_rdy", r0, 0);
        tick();
        chk("s0_stall_v", v0, 1);
        chk("s0_stall_d", d0, 8);
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("s0_drain_v", v0, 0);
        chk("s0_drain_c", c0, 0);

        // Counter saturation: 20 killed beats at full throughput
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h100 + i, 8'hFF, 1'b1, 1'b0, 1'b1);
            tick();
        end
        chk("sat_b1", b1, 4'hF);
        chk("sat_b0", b0, 20);
        chk("sat_v1", v1, 1);
        chk("sat_d1", d1, 32'h113);
        chk("sat_c1", c1, 0);

        // Reset while FULL
        do_reset();
        drive(1'b1, 32'h60, 8'h44, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h61, 8'h45, 1'b0, 1'b0, 1'b0);
        tick();
        chk("full_r1", r1, 0);
        chk("full_b1", b1, 1);
        drive(1'b1, 32'h62, 8'h46, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        chk("mrst_v1", v1, 0);
        chk("mrst_d1", d1, 0);
        chk("mrst_c1", c1, 0);
        chk("mrst_b1", b1, 0);
        chk("mrst_r1", r1, 1);
        tick();
        chk("mrst_after_v1", v1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register, the successor to the fixed-field ID/EX latch. Carries an opaque payload plus a control field between any two stages of the 5-stage core. Adds a valid/ready handshake, stall (back-pressure), whole-stage flush, and per-beat control kill (bubble insertion). An optional 2-entry skid mode breaks the combinational ready path.

## Interface
- DATA_W, 160, payload width in bits (pc, operands, imm, register addresses, cycle).
- CTRL_W, 8, control-field width; these bits are forced to 0 on kill/flush.
- SKID, 0, 0 = single entry with combinational in_ready; 1 = two entries (main + skid) with registered in_ready.
- CNT_W, 16, width of the bubble counter.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- kill_in  in  1  accept the incoming beat but zero its ctrl (load-use / branch bubble).
- flush  in  1  discard all held beats and any incoming beat.
- out_valid  out  1  beat held for downstream.
- out_ready  in  1  downstream consumes the beat.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control field.
- bubble_cnt  out  CNT_W  saturating count of killed beats.

## Operation
- Accept = in_valid & in_ready & ~flush. Drain = out_valid & out_ready.
- Captured ctrl = kill_in ? 0 : in_ctrl. Data is always captured as presented. A killed beat stays valid.
- SKID=0: in_ready = out_ready | ~out_valid (combinational). Main entry loads on accept. It clears valid on drain without accept.
- SKID=1 states: EMPTY (no entries), ONE (main valid), FULL (main + skid valid). in_ready = ~skid_valid, registered.
  - EMPTY: accept -> ONE.
  - ONE: accept & drain -> ONE (main reloads). Accept & ~drain -> FULL (beat into skid). Drain & ~accept -> EMPTY.
  - FULL: drain -> ONE (skid moves to main). No accept is possible in FULL.
- Ordering is strict FIFO. No beat is ever duplicated or reordered.
- flush: next cycle all valids = 0, out_ctrl = 0, state EMPTY. Same-cycle incoming beat is dropped. Same-cycle drain still completes downstream. out_data keeps its value; it is don't-care.
- flush and kill_in together: flush wins, nothing captured, bubble_cnt unchanged.
- bubble_cnt increments on accept & kill_in and saturates at all-ones.
- rst takes priority over everything.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ctrl = 0, bubble_cnt = 0, state EMPTY.
  - SKID=1: in_ready = 1 from the first cycle after rst deasserts.
  - SKID=0: in_ready follows its equation.
- Inputs in a cycle with rst high are ignored.
- Latency: a beat accepted in cycle N is visible on out_* in cycle N+1, in both modes, when the stage is empty.
- Throughput: one beat per cycle while out_ready = 1, in both modes.
- Stall: out_* held stable while out_valid & ~out_ready.
- SKID=1: in_ready deasserts the cycle after the skid entry fills. It reasserts the cycle after the FULL-state drain.
- rst mid-operation clears all held beats and the counter in one cycle.

## Structure
- Package pipe_pkg:
  - state enum pipe_state_t {EMPTY, ONE, FULL}.
  - Localparam defaults for DATA_W and CTRL_W per core boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.
  - Field-offset constants the core uses to pack and unpack in_data.
- Sub-module pipe_slot: one entry holding valid, data and ctrl, with load and clear. Instantiated once (SKID=0) or twice (SKID=1).

## Test plan
- Pass-through, SKID=0 and SKID=1, out_ready = 1: beats data = 0x1..0x8, ctrl = 0xA5 on consecutive cycles -> out_* shows the same sequence one cycle later, no gaps.
- Stall, SKID=1: out_ready = 0 for 3 cycles while beats 0x10 and 0x11 arrive -> main = 0x10, skid = 0x11, in_ready = 0. out_ready = 1 -> outputs 0x10 then 0x11, in_ready returns to 1.
- Kill: beat data = 0x55, ctrl = 0xFF with kill_in = 1 -> out_valid = 1, out_data = 0x55, out_ctrl = 0x00, bubble_cnt = 1.
- Flush while FULL, with concurrent in_valid: flush = 1 -> next cycle out_valid = 0, out_ctrl = 0, incoming beat never appears, bubble_cnt unchanged.
- Saturation, CNT_W = 4: 20 killed beats -> bubble_cnt stops at 0xF.
- Reset mid-stream: rst = 1 while FULL -> next cycle out_valid = 0, out_data = 0, bubble_cnt = 0. With SKID=1, in_ready = 1 after rst deasserts.
